mix_sched: RTL and testbench

//  Sequencer/arbiter for the 8-word 32-bit mixing datapath. Runs one mix stage per clock on a shared engine.

---
 rtl/mix_pkg.sv | 31 +++
 rtl/mix_stage.sv | 34 +++
 rtl/mix_sched.sv | 159 +++++++++++++++
 tb/tb_mix_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// mix_pkg: shared word/state types, FSM encoding and stage constants for the
// mixing sequencer (mix_sched) and its combinational stage (mix_stage).
package mix_pkg;

  localparam int WORD_W  = 32;
  localparam int NWORDS  = 8;
  localparam int NSTAGES = 8;
  localparam int DATA_W  = WORD_W * NWORDS;

  localparam int SH_S3  = 16;
  localparam int SH_S4A = 17;
  localparam int SH_S4B = 12;

  typedef logic [WORD_W-1:0]  word_t;
  typedef word_t [NWORDS-1:0] state_t;
  typedef logic [2:0]         stage_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam stage_t LAST_STAGE = stage_t'(NSTAGES - 1);

  localparam word_t MA [NWORDS] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam word_t AA [NWORDS] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam word_t MB [NWORDS] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
  localparam word_t AB [NWORDS] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

endpackage

// File: rtl/mix_stage.sv
// mix_stage: one combinational mixing stage over the 8-word state; words are
// rewritten in ascending order and later words see the already-updated ones.
module mix_stage
  import mix_pkg::*;
(
  input  state_t in_state,
  input  stage_t stage,
  output state_t out_state
);

  state_t o_s;

  // In-place ascending update; 3-bit index arithmetic gives the mod-8 wrap.
  always_comb begin
    o_s = in_state;
    for (int i = 0; i < NWORDS; i++) begin
      case (stage)
        3'd0: o_s[3'(i)] = o_s[3'(i)] + WORD_W'(i);
        3'd1: o_s[3'(i)] = o_s[3'(i)] + o_s[3'(i) + 3'd7];
        3'd2: o_s[3'(i)] = o_s[3'(i)] + o_s[3'(i) + 3'd1] - o_s[3'(i) + 3'd5];
        3'd3: o_s[3'(i)] = o_s[3'(i)] ^ (o_s[3'(i) + 3'd3] << SH_S3);
        3'd4: o_s[3'(i)] = o_s[3'(i)] - (o_s[3'(i) + 3'd2] >> SH_S4A)
                                      + (o_s[3'(i) + 3'd4] >> SH_S4B);
        3'd5: o_s[3'(i)] = o_s[3'(i)] + o_s[3'(i) + 3'd7] - o_s[3'(i) + 3'd6];
        3'd6: o_s[3'(i)] = o_s[3'(i)] * MA[3'(i)] + AA[3'(i)];
        3'd7: o_s[3'(i)] = o_s[3'(i)] * MB[3'(i)] + AB[3'(i)];
        default: o_s[3'(i)] = o_s[3'(i)];
      endcase
    end
  end

  assign out_state = o_s;

endmodule

// File: rtl/mix_sched.sv
// mix_sched: round-robin job arbiter and IDLE/RUN/DONE sequencer driving one
// mix stage per clock. Optional abort input is enabled by MIX_SCHED_ABORT_EN.
module mix_sched
  import mix_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ITER_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef MIX_SCHED_ABORT_EN
  input  logic                    abort,
`endif
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*ITER_W-1:0]  req_iters,
  input  logic [NREQ*DATA_W-1:0]  req_seed,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  fsm_t              state_r, state_nxt_s;
  logic [IDW-1:0]    ptr_r, id_r, gid_s, idx_s;
  logic [NREQ-1:0]   grant_s;
  logic              found_s, accept_s, abort_s, wrap_s, last_s;
  logic [ITER_W-1:0] iters_r, iter_r, gits_s;
  stage_t            stage_r;
  state_t            data_r, mixed_s, gseed_s;
  logic              rsp_valid_r, busy_r;

`ifdef MIX_SCHED_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Round-robin search: first valid requester at or above the pointer, mod NREQ.
  always_comb begin
    grant_s = '0;
    gid_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s        = 1'b1;
        gid_s          = idx_s;
        grant_s[idx_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign req_ready = (state_r == IDLE) ? grant_s : '0;
  assign accept_s  = (state_r == IDLE) && found_s;
  assign gseed_s   = req_seed[32'(gid_s) * DATA_W +: DATA_W];
  assign gits_s    = req_iters[32'(gid_s) * ITER_W +: ITER_W];
  assign wrap_s    = (stage_r == LAST_STAGE);
  assign last_s    = wrap_s && (iter_r == iters_r - ITER_W'(1));

  mix_stage u_stage (
    .in_state  (data_r),
    .stage     (stage_r),
    .out_state (mixed_s)
  );

  // Next-state logic for the job sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = (gits_s == '0) ? DONE : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (abort_s) begin
          state_nxt_s = IDLE;
        end else if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rsp_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  // Job capture, stage/iteration counting and the working state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r   <= '0;
      id_r    <= '0;
      iters_r <= '0;
      iter_r  <= '0;
      stage_r <= '0;
      data_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            data_r  <= gseed_s;
            iters_r <= gits_s;
            id_r    <= gid_s;
            ptr_r   <= (gid_s == LAST_ID) ? '0 : gid_s + IDW'(1);
            stage_r <= '0;
            iter_r  <= '0;
          end
        end
        RUN: begin
          if (!abort_s) begin
            data_r  <= mixed_s;
            stage_r <= stage_r + 3'd1;
            if (wrap_s) begin
              iter_r <= iter_r + ITER_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign busy      = busy_r;
  assign rsp_id    = id_r;
  assign rsp_data  = data_r;

endmodule

// File: tb/tb_mix_sched.sv
// tb_mix_sched: directed bench for mix_sched with a transaction-level reference
// model compared against the DUT on every falling clock edge.
module tb_mix_sched;

  localparam int NREQ   = 2;
  localparam int ITER_W = 8;

  typedef logic [7:0][31:0] blk_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 abort;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*ITER_W-1:0] req_iters;
  logic [NREQ*256-1:0]  req_seed;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [0:0]           rsp_id;
  logic [255:0]         rsp_data;
  logic                 busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mix_sched #(.NREQ(NREQ), .ITER_W(ITER_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MIX_SCHED_ABORT_EN
    .abort     (abort),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_iters (req_iters),
    .req_seed  (req_seed),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic on plain word arrays
  int unsigned MA_T [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
  int unsigned AA_T [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
  int unsigned MB_T [8] = '{2, 3, 3, 3, 5, 13, 35, 87};
  int unsigned AB_T [8] = '{0, 1, 8, 27, 64, 125, 216, 343};

  function automatic blk_t mstage(input blk_t x, input int s);
    blk_t o = x;
    for (int i = 0; i < 8; i++) begin
      case (s)
        0: o[i] = o[i] + 32'(i);
        1: o[i] = o[i] + o[(i + 7) % 8];
        2: o[i] = o[i] + o[(i + 1) % 8] - o[(i + 5) % 8];
        3: o[i] = o[i] ^ (o[(i + 3) % 8] << 16);
        4: o[i] = o[i] - (o[(i + 2) % 8] >> 17) + (o[(i + 4) % 8] >> 12);
        5: o[i] = o[i] + o[(i + 7) % 8] - o[(i + 6) % 8];
        6: o[i] = o[i] * MA_T[i] + AA_T[i];
        default: o[i] = o[i] * MB_T[i] + AB_T[i];
      endcase
    end
    return o;
  endfunction

  function automatic blk_t model_job(input blk_t seed, input int iters);
    blk_t o = seed;
    for (int it = 0; it < iters; it++)
      for (int s = 0; s < 8; s++)
        o = mstage(o, s);
    return o;
  endfunction

  // Transaction-level model: phase 0 idle, 1 running, 2 result pending
  int   m_phase, m_left, m_ptr, m_id;
  blk_t m_data;

  function automatic int mgrant();
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int iters_of(input int r);
    return int'(req_iters[r*ITER_W +: ITER_W]);
  endfunction

  function automatic blk_t seed_of(input int r);
    return req_seed[r*256 +: 256];
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    if (m_phase == 0 && mgrant() >= 0) return NREQ'(1) << mgrant();
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_left <= 0; m_ptr <= 0; m_id <= 0; m_data <= '0;
    end else begin
      case (m_phase)
        0: if (mgrant() >= 0) begin
             m_id   <= mgrant();
             m_ptr  <= (mgrant() + 1) % NREQ;
             m_data <= model_job(seed_of(mgrant()), iters_of(mgrant()));
             if (iters_of(mgrant()) == 0) m_phase <= 2;
             else begin m_phase <= 1; m_left <= 8 * iters_of(mgrant()); end
           end
        1: if (abort) m_phase <= 0;
           else begin
             m_left <= m_left - 1;
             if (m_left == 1) m_phase <= 2;
           end
        default: if (rsp_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", req_ready, exp_ready());
      check("rsp_valid", rsp_valid, m_phase == 2);
      check("busy", busy, m_phase != 0);
      if (m_phase == 2) begin
        check("rsp_id", rsp_id, m_id[0]);
        check("rsp_data", rsp_data, m_data);
      end
    end
  end

  task automatic accept_wait(input int r, output logic [NREQ-1:0] rdy, output int n);
    n = 0;
    @(negedge clk);
    while (!req_ready[r] && n < 200) begin @(negedge clk); n++; end
    rdy = req_ready;
    check("accept_seen", req_ready[r], 1'b1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  // Called one step after the accept edge; returns k where rsp_valid first rises in cycle T+k
  task automatic wait_rsp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t iota, seed_b;
    logic [NREQ-1:0] rdy;
    int n, lat;
    iota   = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    seed_b = {32'h89abcdef, 32'h01234567, 32'hfedcba98, 32'h76543210,
              32'h0f1e2d3c, 32'h4b5a6978, 32'hdeadbeef, 32'hcafef00d};
    rst_n = 1'b0; abort = 1'b0; req_valid = '0; req_iters = '0; req_seed = '0; rsp_ready = 1'b1;

    // Pin the model's stage arithmetic against hand-computed values
    check("pin_s0", mstage(iota, 0), {32'd14, 32'd12, 32'd10, 32'd8, 32'd6, 32'd4, 32'd2, 32'd0});
    check("pin_s1", mstage(iota, 1), {32'd35, 32'd28, 32'd22, 32'd17, 32'd13, 32'd10, 32'd8, 32'd7});
    check("pin_s2", mstage(iota, 2), {32'hfffffff7, 32'd2, 32'd13, 32'd12, 32'd11,
                                      32'hfffffffe, 32'hfffffffd, 32'hfffffffc});
    check("pin_s6", mstage(iota, 6), {32'd156, 32'd121, 32'd82, 32'd57, 32'd32, 32'd17, 32'd8, 32'd3});

    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_data", rsp_data, 256'd0);
    check("rst_req_ready", req_ready, 2'b00);
    rst_n = 1'b1;

    // 1: req0, one iteration
    req_seed[255:0] = iota; req_iters[7:0] = 8'd1; req_valid = 2'b01;
    accept_wait(0, rdy, n);
    wait_rsp(lat);
    check("t1_latency", lat, 9);
    check("t1_id", rsp_id, 1'b0);
    check("t1_data", rsp_data, model_job(iota, 1));
    @(posedge clk); #1;

    // 2: req1, zero iterations returns the seed
    req_seed[511:256] = iota; req_iters[15:8] = 8'd0; req_valid = 2'b10;
    accept_wait(1, rdy, n);
    wait_rsp(lat);
    check("t2_latency", lat, 1);
    check("t2_data", rsp_data, {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0});
    check("t2_id", rsp_id, 1'b1);
    @(posedge clk); #1;

    // 3: both valid right after reset, two iterations each
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_seed = {seed_b, iota}; req_iters = {8'd2, 8'd2}; req_valid = 2'b11;
    accept_wait(0, rdy, n);
    check("t3_first_grant", rdy, 2'b01);
    wait_rsp(lat);
    check("t3_latency0", lat, 17);
    check("t3_id0", rsp_id, 1'b0);
    accept_wait(1, rdy, n);
    check("t3_second_grant", rdy, 2'b10);
    check("t3_regrant_gap", n, 0);
    wait_rsp(lat);
    check("t3_latency1", lat, 17);
    check("t3_id1", rsp_id, 1'b1);
    check("t3_data1", rsp_data, model_job(seed_b, 2));
    @(posedge clk); #1;

    // 4: consumer stalls 5 cycles; req1 waits, must not be granted in DONE
    rsp_ready = 1'b0;
    req_seed = {iota, seed_b}; req_iters = {8'd0, 8'd3}; req_valid = 2'b01;
    accept_wait(0, rdy, n);
    req_valid[1] = 1'b1;
    wait_rsp(lat);
    check("t4_latency", lat, 25);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("t4_hold_data", rsp_data, model_job(seed_b, 3));
      check("t4_hold_id", rsp_id, 1'b0);
      check("t4_no_grant", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    accept_wait(1, rdy, n);
    wait_rsp(lat);
    check("t4_next_latency", lat, 1);
    check("t4_next_id", rsp_id, 1'b1);
    @(posedge clk); #1;

    // 5: reset in the fourth RUN cycle discards the job and the pointer
    req_seed = {seed_b, seed_b}; req_iters = {8'd0, 8'd2}; req_valid = 2'b01;
    accept_wait(0, rdy, n);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_iters = {8'd0, 8'd0}; req_valid = 2'b11;
    accept_wait(0, rdy, n);
    check("t5_grant_after_reset", rdy, 2'b01);
    wait_rsp(lat);
    check("t5_latency0", lat, 1);
    accept_wait(1, rdy, n);
    wait_rsp(lat);
    check("t5_id1", rsp_id, 1'b1);
    @(posedge clk); #1;

`ifdef MIX_SCHED_ABORT_EN
    // 6: abort in the third RUN cycle; pending req1 granted next
    req_seed = {iota, seed_b}; req_iters = {8'd0, 8'd3}; req_valid = 2'b11;
    accept_wait(0, rdy, n);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    accept_wait(1, rdy, n);
    check("t6_grant_after_abort", n, 0);
    check("t6_grant", rdy, 2'b10);
    wait_rsp(lat);
    check("t6_latency", lat, 1);
    check("t6_id", rsp_id, 1'b1);
    check("t6_data", rsp_data, iota);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
